// File: rtl/uart_frame_parser.sv
// ---------------------------------------------------------------------------
// uart_frame_parser
//
// Command-frame parser that sits directly behind the RS422 main-link UART
// receiver. It consumes one byte per rx_valid strobe and hunts for frames of
// the form:
//
//   HEAD0 HEAD1 P0 P1 P2 P3 P4 CHK TAIL      (CHK = P0^P1^P2^P3^P4)
//
// A good frame updates frame_data and raises frame_valid for one cycle.
// Checksum, tail and inter-byte timeout errors each raise a one-cycle pulse.
// The good-frame and error counters saturate at 16'hFFFF.
//
// Ports:
//   clk          system clock (50 MHz)
//   rst_n        asynchronous active-low reset
//   rx_data      received byte, valid when rx_valid is high
//   rx_valid     one-cycle byte strobe
//   frame_valid  one-cycle pulse, good frame accepted
//   frame_data   payload, P0 in [39:32] ... P4 in [7:0]; held until next good frame
//   chk_err      one-cycle pulse, checksum mismatch with correct tail
//   tail_err     one-cycle pulse, tail byte incorrect
//   timeout_err  one-cycle pulse, inter-byte gap too long inside a frame
//   frame_cnt    saturating count of good frames
//   err_cnt      saturating count of error pulses
//   busy         parser is inside a frame (state is not IDLE)
// ---------------------------------------------------------------------------
module uart_frame_parser #(
    parameter logic [7:0] HEAD0          = 8'hAA,
    parameter logic [7:0] HEAD1          = 8'h55,
    parameter logic [7:0] TAIL           = 8'hEF,
    parameter int         TIMEOUT_CYCLES = 8680
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        frame_valid,
    output logic [39:0] frame_data,
    output logic        chk_err,
    output logic        tail_err,
    output logic        timeout_err,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR1    = 3'd1;
    localparam logic [2:0] ST_PAYLOAD = 3'd2;
    localparam logic [2:0] ST_CHK     = 3'd3;
    localparam logic [2:0] ST_TAIL    = 3'd4;

    // The counter never needs to hold more than TIMEOUT_CYCLES-1.
    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]      state;
    logic [2:0]      idx;
    logic [7:0]      acc;
    logic [39:0]     shadow;
    logic            chk_ok;
    logic [TO_W-1:0] to_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign busy = (state != ST_IDLE);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others, independent of
    // statement order inside the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            acc         <= '0;
            shadow      <= '0;
            chk_ok      <= 1'b0;
            to_cnt      <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            chk_err     <= 1'b0;
            tail_err    <= 1'b0;
            timeout_err <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            // Pulses are single-cycle unless re-asserted below.
            frame_valid <= 1'b0;
            chk_err     <= 1'b0;
            tail_err    <= 1'b0;
            timeout_err <= 1'b0;

            if (rx_valid) begin
                // A byte always restarts the gap timer, even in the cycle the
                // timer would otherwise expire.
                to_cnt <= '0;
                unique case (state)
                    ST_IDLE: begin
                        if (rx_data == HEAD0) state <= ST_HDR1;
                    end
                    ST_HDR1: begin
                        if (rx_data == HEAD1) begin
                            state <= ST_PAYLOAD;
                            idx   <= '0;
                            acc   <= '0;
                        end else if (rx_data != HEAD0) begin
                            // A repeated HEAD0 keeps us here to resync.
                            state <= ST_IDLE;
                        end
                    end
                    ST_PAYLOAD: begin
                        // Header values are plain data at this point.
                        shadow <= {shadow[31:0], rx_data};
                        acc    <= acc ^ rx_data;
                        if (idx == 3'd4) state <= ST_CHK;
                        else             idx   <= idx + 3'd1;
                    end
                    ST_CHK: begin
                        chk_ok <= (rx_data == acc);
                        state  <= ST_TAIL;
                    end
                    ST_TAIL: begin
                        // A bad tail outranks a bad checksum.
                        if (rx_data != TAIL) begin
                            tail_err <= 1'b1;
                            err_cnt  <= sat_inc(err_cnt);
                        end else if (!chk_ok) begin
                            chk_err <= 1'b1;
                            err_cnt <= sat_inc(err_cnt);
                        end else begin
                            frame_data  <= shadow;
                            frame_valid <= 1'b1;
                            frame_cnt   <= sat_inc(frame_cnt);
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (state == ST_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
                // Gap expired inside a frame: drop the partial frame.
                timeout_err <= 1'b1;
                err_cnt     <= sat_inc(err_cnt);
                state       <= ST_IDLE;
                to_cnt      <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Command-frame parser directly downstream of the RS422 main-link UART receiver on the EP4CE10 board.
- Consumes one received byte per rx_valid strobe and hunts for frames of the form AA 55, five payload bytes, XOR checksum, EF.
- On a good frame, presents the 40-bit payload with a one-cycle valid pulse to the decoder/power-control logic (cd4514/cd4555/pwr_en drivers).
- Flags checksum, tail and inter-byte timeout errors, and keeps saturating frame and error counters.

Parameters:
- HEAD0, 8'hAA, first header byte.
- HEAD1, 8'h55, second header byte.
- TAIL, 8'hEF, tail byte.
- TIMEOUT_CYCLES, 8680, clk cycles allowed between bytes inside a frame (two byte times at 115200 baud, 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle.
- frame_valid  out  1  one-cycle pulse: a good frame has been accepted.
- frame_data  out  40  payload; byte0 in [39:32], byte4 in [7:0].
- chk_err  out  1  one-cycle pulse: XOR checksum mismatch, tail correct.
- tail_err  out  1  one-cycle pulse: tail byte is not TAIL.
- timeout_err  out  1  one-cycle pulse: inter-byte timeout inside a frame.
- frame_cnt  out  16  count of good frames, saturating at 16'hFFFF.
- err_cnt  out  16  count of chk_err + tail_err + timeout_err events, saturating at 16'hFFFF.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: all outputs 0. State IDLE; byte index, XOR accumulator and timeout counter all 0.
- All state updates happen on an rx_valid cycle, except timeout handling.
- IDLE:
  - rx_data==HEAD0 -> HDR1.
  - Any other byte is discarded.
- HDR1:
  - rx_data==HEAD1 -> PAYLOAD; clear index and accumulator.
  - rx_data==HEAD0 -> stay in HDR1 (resync on repeated AA).
  - Any other byte -> IDLE, with no error pulse.
- PAYLOAD:
  - Each byte is shifted into the payload shadow register (MSB-first byte order).
  - Accumulator ^= byte; index increments.
  - After the 5th byte (index 4) -> CHK.
  - Header values arriving here are treated as data.
- CHK:
  - Register chk_ok = (rx_data == accumulator) -> TAIL.
- TAIL, on rx_valid:
  - rx_data!=TAIL: tail_err pulse. Takes priority over checksum.
  - rx_data==TAIL and !chk_ok: chk_err pulse.
  - rx_data==TAIL and chk_ok: frame_data <= shadow, frame_valid pulse, frame_cnt+1.
  - Always -> IDLE.
- Latency: frame_valid, chk_err and tail_err assert in the cycle after the tail byte's rx_valid cycle (registered outputs).
- frame_data holds its value until the next good frame. Bad frames never modify it.
- Timeout:
  - In any state other than IDLE, the counter increments every cycle and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid: one-cycle timeout_err pulse next cycle, err_cnt+1, state -> IDLE, partial frame dropped.
  - If rx_valid arrives in the same cycle as expiry, the byte wins and there is no timeout.
  - In IDLE, the counter is held at 0.
- Error pulses are mutually exclusive; at most one per frame attempt.
- err_cnt increments once per pulse. Both counters stick at 16'hFFFF.
- rx_valid is never asserted on consecutive cycles by the receiver. The parser nonetheless accepts back-to-back strobes, one byte per cycle.
- Reset asserted mid-frame: returns immediately to IDLE with all outputs 0. No pulse is generated on reset release.

Test Plan:
- Bytes 01 02 AA 55 05 02 00 00 00 07 EF -> leading 01 02 ignored; frame_valid one cycle after EF strobe; frame_data=40'h0502000000; frame_cnt=1; err_cnt=0.
- AA 55 01 02 03 04 05 02 EF (XOR=01) -> chk_err pulse; no frame_valid; frame_data unchanged; err_cnt=1. Then AA 55 01 02 03 04 05 01 EF -> frame_valid, frame_data=40'h0102030405.
- AA 55 05 00 10 01 01 15 EE -> tail_err only (no chk_err). Same frame with EF -> frame_valid, frame_data=40'h0500100101.
- AA 55 05 then 8680 idle cycles -> single timeout_err, busy drops, err_cnt+1. Following AA 55 05 01 00 00 01 05 EF -> frame_valid, frame_data=40'h0501000001.
- AA AA 55 05 02 00 00 00 07 EF -> resync accepted, frame_valid. AA 12 55 ... -> no frame, no error.
- rst_n pulsed low after AA 55 05 02 -> outputs 0, state IDLE. The remaining bytes 00 00 00 07 EF produce no pulses.
